// File: rtl/regfile_sb.sv
// regfile_sb: multi-port MIPS register file with a load scoreboard.
// Port 0 is ALU writeback, port 1 is load writeback (which also clears the
// busy bit). Reads are combinational; r0 is hard-wired to zero.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data to the read ports and drop rbusy in the load writeback cycle.
module regfile_sb #(
    parameter int REGS_NUM   = 32,
    parameter int REGS_WIDTH = 32,
    parameter int RD_PORTS   = 2,
    localparam int ADDR_W    = $clog2(REGS_NUM)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [RD_PORTS*ADDR_W-1:0]     ra,
    output logic [RD_PORTS*REGS_WIDTH-1:0] rd,
    output logic [RD_PORTS-1:0]            rbusy,
    input  logic                           we0,
    input  logic [ADDR_W-1:0]              waddr0,
    input  logic [REGS_WIDTH-1:0]          wdata0,
    input  logic                           we1,
    input  logic [ADDR_W-1:0]              waddr1,
    input  logic [REGS_WIDTH-1:0]          wdata1,
    input  logic                           claim_en,
    input  logic [ADDR_W-1:0]              claim_addr,
    output logic [REGS_NUM-1:0]            busy,
    output logic                           sb_err
);

    logic [REGS_WIDTH-1:0] regs_q [REGS_NUM];
    logic [REGS_NUM-1:0]   busy_q, busy_d;
    logic                  sb_err_q, sb_err_d;

    // Register array update; port 1 is written last so it wins a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REGS_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (we0 && (waddr0 != '0)) begin
                regs_q[waddr0] <= wdata0;
            end
            if (we1 && (waddr1 != '0)) begin
                regs_q[waddr1] <= wdata1;
            end
        end
    end

    // Scoreboard next state: clear on load writeback, then set on claim so a
    // back-to-back load to the same register keeps it busy.
    always_comb begin
        busy_d   = busy_q;
        sb_err_d = sb_err_q;
        if (we1 && (waddr1 != '0)) begin
            // Load writeback with no outstanding load on that register.
            if (!busy_q[waddr1]) begin
                sb_err_d = 1'b1;
            end
            busy_d[waddr1] = 1'b0;
        end
        if (claim_en && (claim_addr != '0)) begin
            // Re-claim is legal only when the old load retires this cycle.
            if (busy_q[claim_addr] && !(we1 && (waddr1 == claim_addr))) begin
                sb_err_d = 1'b1;
            end
            busy_d[claim_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard state registers; the error flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            sb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            sb_err_q <= sb_err_d;
        end
    end

    // Combinational read ports with optional same-cycle forwarding.
    always_comb begin
        rd    = '0;
        rbusy = '0;
        for (int i = 0; i < RD_PORTS; i++) begin
            if (!rst && (ra[i*ADDR_W +: ADDR_W] != '0)) begin
                rd[i*REGS_WIDTH +: REGS_WIDTH] = regs_q[ra[i*ADDR_W +: ADDR_W]];
                rbusy[i] = busy_q[ra[i*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
                if (we0 && (waddr0 == ra[i*ADDR_W +: ADDR_W])) begin
                    rd[i*REGS_WIDTH +: REGS_WIDTH] = wdata0;
                end
                // Load data overrides ALU data and releases the stall now.
                if (we1 && (waddr1 == ra[i*ADDR_W +: ADDR_W])) begin
                    rd[i*REGS_WIDTH +: REGS_WIDTH] = wdata1;
                    rbusy[i] = 1'b0;
                end
`endif
            end
        end
    end

    assign busy   = busy_q;
    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb with default parameters (32 x 32, two read ports).
// Expected values for the forwarding cases follow REGFILE_BYPASS_EN.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rbusy;
    logic        we0, we1, claim_en;
    logic [4:0]  waddr0, waddr1, claim_addr;
    logic [31:0] wdata0, wdata1;
    logic [31:0] busy;
    logic        sb_err;

    int checks = 0;
    int errors = 0;
    string tag;
    logic [31:0] exp_q[$];

    regfile_sb dut (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rbusy(rbusy),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .busy(busy), .sb_err(sb_err)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic        we0;
        logic [4:0]  waddr0;
        logic [31:0] wdata0;
        logic        we1;
        logic [4:0]  waddr1;
        logic [31:0] wdata1;
        logic        cl;
        logic [4:0]  cla;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_rbusy;
        logic [31:0] e_busy;
        logic        e_err;
    } vec_t;

    vec_t tbl [21];

    task automatic drive(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic ce, input logic [4:0] ca,
                         input logic [4:0] r0, input logic [4:0] r1);
        we0 = w0; waddr0 = a0; wdata0 = d0;
        we1 = w1; waddr1 = a1; wdata1 = d1;
        claim_en = ce; claim_addr = ca;
        ra = {r1, r0};
    endtask

    task automatic expect5(input logic [31:0] e_rd0, input logic [31:0] e_rd1,
                           input logic [1:0] e_rbusy, input logic [31:0] e_busy,
                           input logic e_err);
        exp_q.push_back(e_rd0);
        exp_q.push_back(e_rd1);
        exp_q.push_back({30'b0, e_rbusy});
        exp_q.push_back(e_busy);
        exp_q.push_back({31'b0, e_err});
    endtask

    task automatic chk(input string nm, input logic [31:0] act);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s.%s: got %h but scoreboard queue empty", tag, nm, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL %s.%s: got %h expected %h", tag, nm, act, e);
            end
        end
    endtask

    // Sample away from the posedge, after inputs settle.
    task automatic sample();
        #2;
        chk("rd0", rd[31:0]);
        chk("rd1", rd[63:32]);
        chk("rbusy", {30'b0, rbusy});
        chk("busy", busy);
        chk("sb_err", {31'b0, sb_err});
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, r0, r1);
    endtask

    initial begin
        // Reset for two cycles; r0 writes in the table must have no effect.
        rst = 1'b1;
        idle(5'd5, 5'd7);
        repeat (2) @(negedge clk);
        tag = "reset";
        expect5(32'h0, 32'h0, 2'b00, 32'h0, 1'b0);
        sample();
        @(negedge clk);
        rst = 1'b0;

        //            we0 wa0  wd0           we1 wa1  wd1           cl cla  ra0    ra1    rd0           rd1           rb     busy          err
        tbl[0]  = '{1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0};
        tbl[2]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd0, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0};
        tbl[3]  = '{1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 1'b0, 5'd0, 5'd1, 5'd2, 32'h0, 32'h0, 2'b00, 32'h20, 1'b0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5, 32'h22, 32'h22, 2'b00, 32'h0, 1'b0};
        tbl[5]  = '{1'b1, 5'd10, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'h22, 32'h0, 2'b00, 32'h0, 1'b0};
        tbl[6]  = '{1'b1, 5'd11, 32'h12345678, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd5, 32'hA5A5A5A5, 32'h22, 2'b00, 32'h0, 1'b0};
        tbl[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd11, 5'd7, 32'h12345678, 32'h0, 2'b00, 32'h0, 1'b0};
        tbl[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd11, 32'h0, 32'h12345678, 2'b01, 32'h80, 1'b0};
        tbl[9]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 5'd11, 5'd10, 32'h12345678, 32'hA5A5A5A5, 2'b00, 32'h80, 1'b0};
        tbl[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 32'h1234, 32'h0, 2'b00, 32'h0, 1'b0};
        tbl[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd7, 32'h0, 32'h1234, 2'b00, 32'h0, 1'b0};
        tbl[12] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h55, 1'b1, 5'd7, 5'd10, 5'd11, 32'hA5A5A5A5, 32'h12345678, 2'b00, 32'h80, 1'b0};
        tbl[13] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h55, 32'h55, 2'b11, 32'h80, 1'b0};
        tbl[14] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h66, 1'b0, 5'd0, 5'd0, 5'd10, 32'h0, 32'hA5A5A5A5, 2'b00, 32'h80, 1'b0};
        tbl[15] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 32'h66, 32'h0, 2'b00, 32'h0, 1'b0};
        tbl[16] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0};
        tbl[17] = '{1'b1, 5'd12, 32'hCAFE, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 32'h1000, 1'b0};
        tbl[18] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd0, 32'hCAFE, 32'h0, 2'b01, 32'h1000, 1'b0};
        tbl[19] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hBEEF, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 32'h1000, 1'b0};
        tbl[20] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd0, 32'hBEEF, 32'h0, 2'b00, 32'h0, 1'b0};

        for (int i = 0; i < 21; i++) begin
            tag = $sformatf("vec%0d", i);
            drive(tbl[i].we0, tbl[i].waddr0, tbl[i].wdata0, tbl[i].we1, tbl[i].waddr1,
                  tbl[i].wdata1, tbl[i].cl, tbl[i].cla, tbl[i].ra0, tbl[i].ra1);
            expect5(tbl[i].e_rd0, tbl[i].e_rd1, tbl[i].e_rbusy, tbl[i].e_busy, tbl[i].e_err);
            sample();
            @(negedge clk);
        end

        // Forwarding on load writeback: r9 holds 0x77 and is busy.
        tag = "byp_setup";
        drive(1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd0);
        expect5(32'h0, 32'h0, 2'b00, 32'h0, 1'b0);
        sample();
        @(negedge clk);
        tag = "byp_busy";
        idle(5'd0, 5'd9);
        expect5(32'h0, 32'h77, 2'b10, 32'h200, 1'b0);
        sample();
        @(negedge clk);
        tag = "byp_wb";
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hAB, 1'b0, 5'd0, 5'd0, 5'd9);
`ifdef REGFILE_BYPASS_EN
        expect5(32'h0, 32'hAB, 2'b00, 32'h200, 1'b0);
`else
        expect5(32'h0, 32'h77, 2'b10, 32'h200, 1'b0);
`endif
        sample();
        @(negedge clk);
        tag = "byp_after";
        idle(5'd0, 5'd9);
        expect5(32'h0, 32'hAB, 2'b00, 32'h0, 1'b0);
        sample();
        @(negedge clk);

        // Both ports write r13 in one cycle while it is read.
        tag = "dbl_claim";
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 5'd0, 5'd0);
        expect5(32'h0, 32'h0, 2'b00, 32'h0, 1'b0);
        sample();
        @(negedge clk);
        tag = "dbl_wr";
        drive(1'b1, 5'd13, 32'h1, 1'b1, 5'd13, 32'h2, 1'b0, 5'd0, 5'd13, 5'd0);
`ifdef REGFILE_BYPASS_EN
        expect5(32'h2, 32'h0, 2'b00, 32'h2000, 1'b0);
`else
        expect5(32'h0, 32'h0, 2'b01, 32'h2000, 1'b0);
`endif
        sample();
        @(negedge clk);
        tag = "dbl_after";
        idle(5'd13, 5'd13);
        expect5(32'h2, 32'h2, 2'b00, 32'h0, 1'b0);
        sample();
        @(negedge clk);

        // Double claim of r3 raises a sticky error.
        tag = "claim1";
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
        expect5(32'h0, 32'h0, 2'b00, 32'h0, 1'b0);
        sample();
        @(negedge clk);
        tag = "claim2";
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
        expect5(32'h0, 32'h0, 2'b01, 32'h8, 1'b0);
        sample();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            tag = $sformatf("err_hold%0d", k);
            idle(5'd3, 5'd0);
            expect5(32'h0, 32'h0, 2'b01, 32'h8, 1'b1);
            sample();
            @(negedge clk);
        end

        // Reset clears everything, including r9 and the error.
        rst = 1'b1;
        idle(5'd9, 5'd7);
        @(negedge clk);
        rst = 1'b0;
        tag = "post_rst";
        expect5(32'h0, 32'h0, 2'b00, 32'h0, 1'b0);
        sample();
        @(negedge clk);

        // Load writeback to a non-busy register: error, but data lands.
        tag = "wb_nobusy";
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h99, 1'b0, 5'd0, 5'd0, 5'd0);
        expect5(32'h0, 32'h0, 2'b00, 32'h0, 1'b0);
        sample();
        @(negedge clk);
        tag = "wb_nobusy_after";
        idle(5'd4, 5'd0);
        expect5(32'h99, 32'h0, 2'b00, 32'h0, 1'b1);
        sample();
        @(negedge clk);

        // Reset in the same cycle as a write and a claim discards both.
        rst = 1'b1;
        drive(1'b1, 5'd6, 32'h42, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd0, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        tag = "rst_override";
        idle(5'd6, 5'd4);
        expect5(32'h0, 32'h0, 2'b00, 32'h0, 1'b0);
        sample();
        @(negedge clk);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expected values never compared", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port MIPS register file with an integrated load scoreboard, for the lab 5/6 pipeline core. It provides `RD_PORTS` combinational read ports and two write ports: ALU writeback on port 0, load writeback on port 1. A busy bit per register tracks outstanding loads so the decode stage can stall. Same-cycle write-to-read forwarding is a compile-time option.

## Interface
- `REGS_NUM`, 32: number of registers; power of two, 8..64.
- `REGS_WIDTH`, 32: data width in bits.
- `RD_PORTS`, 2: number of read ports, 1..4.
- `ADDR_W`: localparam, `$clog2(REGS_NUM)`.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `ra`  in  RD_PORTS*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- `rd`  out  RD_PORTS*REGS_WIDTH  read data, packed the same way as `ra`.
- `rbusy`  out  RD_PORTS  busy flag of the register addressed on each read port.
- `we0`, `waddr0`, `wdata0`  in  1/ADDR_W/REGS_WIDTH  ALU writeback port.
- `we1`, `waddr1`, `wdata1`  in  1/ADDR_W/REGS_WIDTH  load writeback port; also clears busy.
- `claim_en`, `claim_addr`  in  1/ADDR_W  marks a load destination busy.
- `busy`  out  REGS_NUM  full busy vector, registered.
- `sb_err`  out  1  sticky scoreboard protocol error.

## Operation
- Register 0 reads as 0 at all times. Writes to register 0 are ignored, claims of register 0 are ignored, and `busy[0]` is always 0.
- Writes:
  - Port 0 writes `regs[waddr0]` when `we0` is high.
  - Port 1 writes `regs[waddr1]` when `we1` is high.
  - If both ports write the same non-zero address in one cycle, port 1 wins.
- Reads are combinational: `rd[i] = regs[ra[i]]`, subject to bypass (see Configuration).
- Scoreboard:
  - `claim_en` sets `busy[claim_addr]`.
  - `we1` clears `busy[waddr1]`.
  - Port 0 writes never touch `busy`.
- Scoreboard boundary cases:
  - Claim and port-1 clear of the same address in one cycle: claim wins, so busy stays 1 (a new load is issued back-to-back).
  - Claim of a register whose busy bit is already 1 sets `sb_err`.
  - Port-1 write to a register whose busy bit is 0 also sets `sb_err`; the data write still happens.
  - `sb_err` stays high until `rst`.
- `rbusy[i] = busy[ra[i]]`, with the bypass adjustment described under Configuration.
- Reset: all registers 0, `busy` all 0, `sb_err` 0. Consequently, during and after reset `rd` reads 0 and `rbusy` reads 0.
- Reset asserted mid-operation overrides any same-cycle write or claim; that cycle's write is lost.

## Timing
- Write latency is 1 cycle: data presented with `we` at edge N is stored at edge N and readable from the register array after edge N.
- Read latency is 0 cycles: `rd` follows `ra` combinationally.
- Claim latency is 1 cycle: `busy` and `rbusy` rise after the edge that samples `claim_en`.
- A busy clear by a port-1 write is visible in `busy` after the sampling edge. `rbusy` may clear earlier, as described under Configuration.
- No handshakes or back-pressure. Inputs are sampled every edge; the pipeline is responsible for stalling on `rbusy`.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - A read whose address matches an active write in the same cycle returns that cycle's `wdata`. On a double match, port 1 data is returned.
  - `rbusy[i]` is forced to 0 when `we1` is high and `waddr1 == ra[i]`, so a dependent instruction issues in the load's writeback cycle.
  - Address 0 is never bypassed.
- `REGFILE_BYPASS_EN` not defined:
  - `rd` returns stored contents only; new data is visible the cycle after the write.
  - `rbusy` mirrors `busy` directly.

## Test plan
- Reset and r0:
  - Assert `rst` for 2 cycles, then write 0xDEADBEEF to r0 via both ports.
  - Required: all `rd` = 0, `busy` = 0, `sb_err` = 0.
- Dual write collision:
  - Same edge: `we0`=`we1`=1, `waddr0`=`waddr1`=5, `wdata0`=0x11, `wdata1`=0x22.
  - Required: next cycle a read of r5 returns 0x22.
- Claim/clear:
  - Claim r7. Next cycle `busy[7]`=1 and `rbusy`=1 on a port reading r7.
  - Write r7 = 0x1234 via port 1. Next cycle `busy[7]`=0 and r7 reads 0x1234.
- Back-to-back load:
  - With r7 busy, apply claim r7 and port-1 write r7 = 0x55 in the same cycle.
  - Required: `busy[7]` stays 1 and `sb_err` stays 0.
- Protocol errors:
  - Claim r3 twice without an intervening clear → `sb_err`=1 and held until `rst`.
  - Port-1 write to non-busy r4 → `sb_err`=1.
- Bypass, run with and without `REGFILE_BYPASS_EN`:
  - Stimulus: `ra[1]`=9 while r9 is busy, and port-1 writes 0xAB to r9 in that cycle.
  - With the macro: same cycle `rd[1]`=0xAB and `rbusy[1]`=0.
  - Without the macro: old r9 value and `rbusy[1]`=1; 0xAB appears next cycle.
